tnoc_vc_credit_sender: RTL

- Link-side sender that sits directly upstream of the per-VC input FIFOs of the next router's VC selector.
- Accepts a single flit stream tagged with a virtual-channel index.
- Forwards each flit over a ready-less, credit-based link.
- Keeps one credit counter per VC, mirroring free space in the downstream FIFO of depth FIFO_DEPTH; a flit is never sent unless its VC holds a credit.

---
 rtl/tnoc_credit_pkg.sv | 10 +
 rtl/tnoc_vc_credit_sender_if.sv | 36 +++
 rtl/tnoc_credit_counter.sv | 33 +++
 rtl/tnoc_vc_credit_sender.sv | 117 +++++++++++
 4 files changed

// File: rtl/tnoc_credit_pkg.sv
// Shared types and helpers for the credit-based VC link sender.
package tnoc_credit_pkg;

  typedef enum logic {IDLE = 1'b0, IN_PACKET = 1'b1} tnoc_pkt_state;

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tnoc_vc_credit_sender_if.sv
// Upstream flit stream, credit link and debug state of tnoc_vc_credit_sender.
// master = flit source / link partner side, slave = the sender block.
interface tnoc_vc_credit_sender_if
  import tnoc_credit_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int FLIT_WIDTH   = 64,
  parameter int FIFO_DEPTH   = 8,
  parameter int VC_WIDTH     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int CREDIT_WIDTH = credit_width(FIFO_DEPTH)
);
  logic                             i_valid;
  logic                             o_ready;
  logic [VC_WIDTH-1:0]              i_vc;
  logic                             i_head;
  logic                             i_tail;
  logic [FLIT_WIDTH-1:0]            i_flit;
  logic                             o_valid;
  logic [VC_WIDTH-1:0]              o_vc;
  logic                             o_head;
  logic                             o_tail;
  logic [FLIT_WIDTH-1:0]            o_flit;
  logic [CHANNELS-1:0]              i_credit_return;
  logic [CHANNELS*CREDIT_WIDTH-1:0] o_credit_count;
  tnoc_pkt_state                    o_pkt_state;

  modport master (
    output i_valid, i_vc, i_head, i_tail, i_flit, i_credit_return,
    input  o_ready, o_valid, o_vc, o_head, o_tail, o_flit, o_credit_count, o_pkt_state
  );

  modport slave (
    input  i_valid, i_vc, i_head, i_tail, i_flit, i_credit_return,
    output o_ready, o_valid, o_vc, o_head, o_tail, o_flit, o_credit_count, o_pkt_state
  );
endinterface

// File: rtl/tnoc_credit_counter.sv
// Per-VC credit counter mirroring free slots in one downstream FIFO.
module tnoc_credit_counter
  import tnoc_credit_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = credit_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_consume,
  input  logic             i_return,
  output logic [WIDTH-1:0] o_count,
  output logic             o_available,
  output logic             o_overflow
);
  localparam logic [WIDTH-1:0] FULL = WIDTH'(DEPTH);

  logic full;
  assign full        = (o_count == FULL);
  assign o_available = (o_count != '0);
  // A return paired with a send is a legal net-zero update even when full.
  assign o_overflow  = i_return && !i_consume && full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_count <= FULL;
    end else if (i_consume && !i_return) begin
      o_count <= o_count - WIDTH'(1);
    end else if (!i_consume && i_return && !full) begin
      o_count <= o_count + WIDTH'(1);
    end
  end
endmodule

// File: rtl/tnoc_vc_credit_sender.sv
// Credit-gated link sender: one registered flit stage, per-VC credit counters
// and a packet FSM. Define TNOC_CREDIT_CHECK_EN for the sticky o_error checker.
module tnoc_vc_credit_sender
  import tnoc_credit_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int FLIT_WIDTH   = 64,
  parameter int FIFO_DEPTH   = 8,
  parameter int VC_WIDTH     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int CREDIT_WIDTH = credit_width(FIFO_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  tnoc_vc_credit_sender_if.slave    bus
`ifdef TNOC_CREDIT_CHECK_EN
  ,
  output logic                      o_error
`endif
);
  localparam int VC_SLOTS = 1 << VC_WIDTH;

  logic [CHANNELS-1:0]                   consume;
  logic [CHANNELS-1:0]                   avail;
  logic [CHANNELS-1:0]                   overflow;
  logic [CHANNELS-1:0][CREDIT_WIDTH-1:0] count;
  logic [VC_SLOTS-1:0]                   avail_ext;
  logic                                  xfer;
  tnoc_pkt_state                         state;

  // Unused VC encodings read as "no credit", so they can never be sent.
  always_comb begin
    avail_ext                 = '0;
    avail_ext[CHANNELS-1:0]   = avail;
  end

  assign bus.o_ready = avail_ext[bus.i_vc];
  assign xfer        = bus.i_valid && bus.o_ready;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_vc
    assign consume[i] = xfer && (bus.i_vc == VC_WIDTH'(i));

    tnoc_credit_counter #(.DEPTH(FIFO_DEPTH), .WIDTH(CREDIT_WIDTH)) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .i_consume   (consume[i]),
      .i_return    (bus.i_credit_return[i]),
      .o_count     (count[i]),
      .o_available (avail[i]),
      .o_overflow  (overflow[i])
    );

    assign bus.o_credit_count[i*CREDIT_WIDTH +: CREDIT_WIDTH] = count[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.o_valid <= 1'b0;
      bus.o_vc    <= '0;
      bus.o_head  <= 1'b0;
      bus.o_tail  <= 1'b0;
      bus.o_flit  <= '0;
    end else begin
      bus.o_valid <= xfer;
      if (xfer) begin
        bus.o_vc   <= bus.i_vc;
        bus.o_head <= bus.i_head;
        bus.o_tail <= bus.i_tail;
        bus.o_flit <= bus.i_flit;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (xfer) begin
      case (state)
        IDLE:      if (bus.i_head && !bus.i_tail) state <= IN_PACKET;
        IN_PACKET: if (bus.i_tail)                state <= IDLE;
        default:                                  state <= IDLE;
      endcase
    end
  end

  assign bus.o_pkt_state = state;

`ifdef TNOC_CREDIT_CHECK_EN
  logic [VC_WIDTH-1:0] pkt_vc;
  logic err_ovf, err_vc, err_body, err_head, err_pvc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                     pkt_vc <= '0;
    else if (xfer && state == IDLE && bus.i_head && !bus.i_tail) pkt_vc <= bus.i_vc;
  end

  // A flit on an unused VC is never accepted, so flag it when offered.
  assign err_ovf  = |overflow;
  assign err_vc   = bus.i_valid && (int'(bus.i_vc) >= CHANNELS);
  assign err_body = xfer && (state == IDLE) && !bus.i_head;
  assign err_head = xfer && (state == IN_PACKET) && bus.i_head;
  assign err_pvc  = xfer && (state == IN_PACKET) && (bus.i_vc != pkt_vc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_error <= 1'b0;
    else     o_error <= o_error | err_ovf | err_vc | err_body | err_head | err_pvc;
  end

  a_credit_overflow: assert property (@(posedge clk) disable iff (rst) !err_ovf);
  a_vc_range:        assert property (@(posedge clk) disable iff (rst) !err_vc);
  a_body_in_idle:    assert property (@(posedge clk) disable iff (rst) !err_body);
  a_head_in_packet:  assert property (@(posedge clk) disable iff (rst) !err_head);
  a_vc_switch:       assert property (@(posedge clk) disable iff (rst) !err_pvc);
`else
  logic unused_overflow;
  assign unused_overflow = |overflow;
`endif
endmodule
